// File: rtl/ctrl_pkg.sv
// Shared opcodes, state encoding, instruction classes and ALU-select bit
// positions for the hardwired control sequencer.
package ctrl_pkg;

   localparam int OP_W  = 5;
   localparam int NREG  = 16;
   localparam int ALU_W = 14;

   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_HALT  = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU    = 3'd0,
      CLS_MULDIV = 3'd1,
      CLS_UNARY  = 3'd2,
      CLS_NOP    = 3'd3,
      CLS_HALT   = 3'd4,
      CLS_UNDEF  = 3'd5
   } op_class_t;

   localparam int ALU_AND  = 0;
   localparam int ALU_ADD  = 1;
   localparam int ALU_SUB  = 2;
   localparam int ALU_MUL  = 3;
   localparam int ALU_DIV  = 4;
   localparam int ALU_SHR  = 5;
   localparam int ALU_SHRA = 6;
   localparam int ALU_SHL  = 7;
   localparam int ALU_ROR  = 8;
   localparam int ALU_ROL  = 9;
   localparam int ALU_OR   = 10;
   localparam int ALU_NEG  = 11;
   localparam int ALU_NOT  = 12;
   localparam int ALU_RSVD = 13;

   function automatic logic [NREG-1:0] reg_sel(input logic [3:0] r);
      logic [NREG-1:0] s;
      s    = '0;
      s[r] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decode: instruction class, one-hot ALU select and
// undefined-opcode flag.
module instr_decode
   import ctrl_pkg::*;
(
   input  logic [OP_W-1:0]  op_i,
   output op_class_t        cls_o,
   output logic [ALU_W-1:0] alu_o,
   output logic             illegal_o
);

   always_comb begin
      cls_o = CLS_UNDEF;
      alu_o = '0;
      case (op_i)
         OP_ADD:  begin cls_o = CLS_ALU;    alu_o[ALU_ADD]  = 1'b1; end
         OP_SUB:  begin cls_o = CLS_ALU;    alu_o[ALU_SUB]  = 1'b1; end
         OP_AND:  begin cls_o = CLS_ALU;    alu_o[ALU_AND]  = 1'b1; end
         OP_OR:   begin cls_o = CLS_ALU;    alu_o[ALU_OR]   = 1'b1; end
         OP_ROR:  begin cls_o = CLS_ALU;    alu_o[ALU_ROR]  = 1'b1; end
         OP_ROL:  begin cls_o = CLS_ALU;    alu_o[ALU_ROL]  = 1'b1; end
         OP_SHR:  begin cls_o = CLS_ALU;    alu_o[ALU_SHR]  = 1'b1; end
         OP_SHRA: begin cls_o = CLS_ALU;    alu_o[ALU_SHRA] = 1'b1; end
         OP_SHL:  begin cls_o = CLS_ALU;    alu_o[ALU_SHL]  = 1'b1; end
         OP_MUL:  begin cls_o = CLS_MULDIV; alu_o[ALU_MUL]  = 1'b1; end
         OP_DIV:  begin cls_o = CLS_MULDIV; alu_o[ALU_DIV]  = 1'b1; end
         OP_NEG:  begin cls_o = CLS_UNARY;  alu_o[ALU_NEG]  = 1'b1; end
         OP_NOT:  begin cls_o = CLS_UNARY;  alu_o[ALU_NOT]  = 1'b1; end
         OP_NOP:  cls_o = CLS_NOP;
         OP_HALT: cls_o = CLS_HALT;
         default: cls_o = CLS_UNDEF;
      endcase
   end

   assign illegal_o = (cls_o == CLS_UNDEF);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and execute (T3-T6) sequencing that
// drives the datapath's one-hot bus, load-enable, ALU and memory strobes.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RESET   | Clear asserted or first cycle after release; all outputs 0
//   T0      | PC onto bus, load MAR, start PC increment into Z
//   T1      | memory read into MDR; first cycle also writes PC+1 back
//   T2      | MDR onto bus, load IR
//   T3      | first execute step (operand rb, or unary op, or nop/halt)
//   T4      | ALU op with rc into Z, or unary writeback
//   T5      | Z low writeback to ra, or LO load for mul/div
//   T6      | Z high into HI (mul/div only)
//   HALT    | stopped; only Clear exits
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 4
)(
   input  logic             Clock,
   input  logic             Clear,
   input  logic [31:0]      IR,
   input  logic             Stop,
   output logic             PCout,
   output logic             Zlowout,
   output logic             Zhighout,
   output logic             MDRout,
   output logic             LOout,
   output logic             HIout,
   output logic [NREG-1:0]  RegOut,
   output logic             PCin,
   output logic             MARin,
   output logic             MDRin,
   output logic             IRin,
   output logic             Yin,
   output logic             Zin,
   output logic             LOin,
   output logic             HIin,
   output logic [NREG-1:0]  RegIn,
   output logic             IncPC,
   output logic             Read,
   output logic [ALU_W-1:0] AluCtl,
   output logic             Run,
   output logic             Illegal
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;

   logic [OP_W-1:0]  op;
   logic [3:0]       ra, rb, rc;
   op_class_t        cls;
   logic [ALU_W-1:0] alu_sel;
   logic             op_undef;
   logic             ir_unused;

   assign op        = IR[31:27];
   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign ir_unused = ^IR[14:0];

   instr_decode u_decode (
      .op_i      (op),
      .cls_o     (cls),
      .alu_o     (alu_sel),
      .illegal_o (op_undef)
   );

   // Stop is only honoured on the edge that would otherwise return to T0.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_T2;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         S_T2:    state_d = S_T3;
         S_T3: begin
            case (cls)
               CLS_ALU, CLS_MULDIV, CLS_UNARY: state_d = S_T4;
               CLS_NOP:  state_d = Stop ? S_HALT : S_T0;
               CLS_HALT: state_d = S_HALT;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_T4: begin
            if (cls == CLS_ALU || cls == CLS_MULDIV) state_d = S_T5;
            else                                      state_d = Stop ? S_HALT : S_T0;
         end
         S_T5: begin
            if (cls == CLS_MULDIV) state_d = S_T6;
            else                   state_d = Stop ? S_HALT : S_T0;
         end
         S_T6:    state_d = Stop ? S_HALT : S_T0;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q   <= S_RESET;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      PCout    = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      MDRout   = 1'b0;
      LOout    = 1'b0;
      HIout    = 1'b0;
      RegOut   = '0;
      PCin     = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      LOin     = 1'b0;
      HIin     = 1'b0;
      RegIn    = '0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      AluCtl   = '0;
      Run      = 1'b0;
      case (state_q)
         S_T0: begin
            Run   = 1'b1;
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Run   = 1'b1;
            Read  = 1'b1;
            MDRin = 1'b1;
            if (cnt_q == '0) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
            end
         end
         S_T2: begin
            Run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Run = 1'b1;
            if (cls == CLS_ALU || cls == CLS_MULDIV) begin
               RegOut = reg_sel(rb);
               Yin    = 1'b1;
            end else if (cls == CLS_UNARY) begin
               RegOut = reg_sel(rb);
               AluCtl = alu_sel;
               Zin    = 1'b1;
            end
         end
         S_T4: begin
            Run = 1'b1;
            if (cls == CLS_ALU || cls == CLS_MULDIV) begin
               RegOut = reg_sel(rc);
               AluCtl = alu_sel;
               Zin    = 1'b1;
            end else if (cls == CLS_UNARY) begin
               Zlowout = 1'b1;
               RegIn   = reg_sel(ra);
            end
         end
         S_T5: begin
            Run = 1'b1;
            if (cls == CLS_MULDIV) begin
               Zlowout = 1'b1;
               LOin    = 1'b1;
            end else if (cls == CLS_ALU) begin
               Zlowout = 1'b1;
               RegIn   = reg_sel(ra);
            end
         end
         S_T6: begin
            Run = 1'b1;
            if (cls == CLS_MULDIV) begin
               Zhighout = 1'b1;
               HIin     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign Illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table-driven instruction
// sequences at MEM_LAT=1 plus directed halt, undefined-op and Clear cases.
module tb_control_sequencer;

   typedef struct packed {
      logic        pc_out, zlo_out, zhi_out, mdr_out, lo_out, hi_out;
      logic [15:0] reg_out;
      logic        pc_in, mar_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in;
      logic [15:0] reg_in;
      logic        inc_pc, rd;
      logic [13:0] alu;
      logic        run, ill;
   } outs_t;

   typedef struct {
      logic [31:0] ir;
      logic        stop;
      outs_t       exp;
   } vec_t;

   localparam logic [31:0] IR_ADD   = 32'h18918000;
   localparam logic [31:0] IR_MUL   = 32'h80228000;
   localparam logic [31:0] IR_NOT   = 32'h93380000;
   localparam logic [31:0] IR_NOP   = 32'hD0000000;
   localparam logic [31:0] IR_SUBS  = 32'h22AA8000;
   localparam logic [31:0] IR_SUB   = 32'h20918000;
   localparam logic [31:0] IR_HALT  = 32'hD8000000;
   localparam logic [31:0] IR_UNDEF = 32'hF8000000;

   localparam logic [13:0] A_ADD = 14'h0002;
   localparam logic [13:0] A_SUB = 14'h0004;
   localparam logic [13:0] A_MUL = 14'h0008;
   localparam logic [13:0] A_NOT = 14'h1000;

   logic        Clock, Clear;
   logic [31:0] IR1, IR3;
   logic        Stop1, Stop3;

   logic        PCout1, Zlowout1, Zhighout1, MDRout1, LOout1, HIout1;
   logic [15:0] RegOut1, RegIn1;
   logic        PCin1, MARin1, MDRin1, IRin1, Yin1, Zin1, LOin1, HIin1;
   logic        IncPC1, Read1, Run1, Illegal1;
   logic [13:0] AluCtl1;

   logic        PCout3, Zlowout3, Zhighout3, MDRout3, LOout3, HIout3;
   logic [15:0] RegOut3, RegIn3;
   logic        PCin3, MARin3, MDRin3, IRin3, Yin3, Zin3, LOin3, HIin3;
   logic        IncPC3, Read3, Run3, Illegal3;
   logic [13:0] AluCtl3;

   outs_t act1, act3;
   int    checks = 0;
   int    errors = 0;
   vec_t  tbl[$];

   control_sequencer #(.MEM_LAT(1), .CNT_W(4)) u_dut1 (
      .Clock(Clock), .Clear(Clear), .IR(IR1), .Stop(Stop1),
      .PCout(PCout1), .Zlowout(Zlowout1), .Zhighout(Zhighout1), .MDRout(MDRout1),
      .LOout(LOout1), .HIout(HIout1), .RegOut(RegOut1),
      .PCin(PCin1), .MARin(MARin1), .MDRin(MDRin1), .IRin(IRin1), .Yin(Yin1),
      .Zin(Zin1), .LOin(LOin1), .HIin(HIin1), .RegIn(RegIn1),
      .IncPC(IncPC1), .Read(Read1), .AluCtl(AluCtl1), .Run(Run1), .Illegal(Illegal1)
   );

   control_sequencer #(.MEM_LAT(3), .CNT_W(4)) u_dut3 (
      .Clock(Clock), .Clear(Clear), .IR(IR3), .Stop(Stop3),
      .PCout(PCout3), .Zlowout(Zlowout3), .Zhighout(Zhighout3), .MDRout(MDRout3),
      .LOout(LOout3), .HIout(HIout3), .RegOut(RegOut3),
      .PCin(PCin3), .MARin(MARin3), .MDRin(MDRin3), .IRin(IRin3), .Yin(Yin3),
      .Zin(Zin3), .LOin(LOin3), .HIin(HIin3), .RegIn(RegIn3),
      .IncPC(IncPC3), .Read(Read3), .AluCtl(AluCtl3), .Run(Run3), .Illegal(Illegal3)
   );

   assign act1 = {PCout1, Zlowout1, Zhighout1, MDRout1, LOout1, HIout1, RegOut1,
                  PCin1, MARin1, MDRin1, IRin1, Yin1, Zin1, LOin1, HIin1, RegIn1,
                  IncPC1, Read1, AluCtl1, Run1, Illegal1};
   assign act3 = {PCout3, Zlowout3, Zhighout3, MDRout3, LOout3, HIout3, RegOut3,
                  PCin3, MARin3, MDRin3, IRin3, Yin3, Zin3, LOin3, HIin3, RegIn3,
                  IncPC3, Read3, AluCtl3, Run3, Illegal3};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic outs_t f_t0();
      outs_t o = '0;
      o.run = 1; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
      return o;
   endfunction

   function automatic outs_t f_t1(input bit first);
      outs_t o = '0;
      o.run = 1; o.rd = 1; o.mdr_in = 1;
      if (first) begin o.zlo_out = 1; o.pc_in = 1; end
      return o;
   endfunction

   function automatic outs_t f_t2();
      outs_t o = '0;
      o.run = 1; o.mdr_out = 1; o.ir_in = 1;
      return o;
   endfunction

   function automatic outs_t f_yin(input logic [15:0] rsel);
      outs_t o = '0;
      o.run = 1; o.reg_out = rsel; o.y_in = 1;
      return o;
   endfunction

   function automatic outs_t f_op(input logic [15:0] rsel, input logic [13:0] a);
      outs_t o = '0;
      o.run = 1; o.reg_out = rsel; o.alu = a; o.z_in = 1;
      return o;
   endfunction

   function automatic outs_t f_wb(input logic [15:0] rsel);
      outs_t o = '0;
      o.run = 1; o.zlo_out = 1; o.reg_in = rsel;
      return o;
   endfunction

   function automatic outs_t f_lo();
      outs_t o = '0;
      o.run = 1; o.zlo_out = 1; o.lo_in = 1;
      return o;
   endfunction

   function automatic outs_t f_hi();
      outs_t o = '0;
      o.run = 1; o.zhi_out = 1; o.hi_in = 1;
      return o;
   endfunction

   function automatic outs_t f_idle(input bit run, input bit ill);
      outs_t o = '0;
      o.run = run; o.ill = ill;
      return o;
   endfunction

   task automatic add_vec(input logic [31:0] ir, input logic stop, input outs_t e);
      vec_t v;
      v.ir = ir; v.stop = stop; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic check_outs(input string nm, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic check_inv(input string nm, input outs_t o);
      checks++;
      if ($countones({o.pc_out, o.zlo_out, o.zhi_out, o.mdr_out, o.lo_out,
                      o.hi_out, o.reg_out}) > 1 ||
          $countones(o.alu) > 1 || (o.inc_pc && !(o.pc_out && o.mar_in))) begin
         errors++;
         $display("FAIL %s invariant: outputs %h", nm, o);
      end
   endtask

   always @(negedge Clock) begin
      check_inv("dut1", act1);
      check_inv("dut3", act3);
   end

   initial begin
      outs_t e1[7];
      outs_t e3[7];
      outs_t eh;

      Clear = 1'b1; IR1 = IR_ADD; IR3 = IR_NOP; Stop1 = 1'b0; Stop3 = 1'b0;

      // Edges between instructions still see the previous IR, so each
      // T0 row keeps the old instruction; the new one is presented from T1.
      add_vec(IR_ADD, 0, f_t0());
      add_vec(IR_ADD, 0, f_t1(1));
      add_vec(IR_ADD, 0, f_t2());
      add_vec(IR_ADD, 0, f_yin(16'h0004));
      add_vec(IR_ADD, 0, f_op(16'h0008, A_ADD));
      add_vec(IR_ADD, 0, f_wb(16'h0002));
      add_vec(IR_ADD, 0, f_t0());
      add_vec(IR_MUL, 0, f_t1(1));
      add_vec(IR_MUL, 0, f_t2());
      add_vec(IR_MUL, 1, f_yin(16'h0010));
      add_vec(IR_MUL, 0, f_op(16'h0020, A_MUL));
      add_vec(IR_MUL, 0, f_lo());
      add_vec(IR_MUL, 0, f_hi());
      add_vec(IR_MUL, 0, f_t0());
      add_vec(IR_NOT, 0, f_t1(1));
      add_vec(IR_NOT, 0, f_t2());
      add_vec(IR_NOT, 0, f_op(16'h0080, A_NOT));
      add_vec(IR_NOT, 0, f_wb(16'h0040));
      add_vec(IR_NOT, 0, f_t0());
      add_vec(IR_NOP, 0, f_t1(1));
      add_vec(IR_NOP, 0, f_t2());
      add_vec(IR_NOP, 0, f_idle(1, 0));
      add_vec(IR_NOP, 0, f_t0());
      add_vec(IR_SUBS, 0, f_t1(1));
      add_vec(IR_SUBS, 0, f_t2());
      add_vec(IR_SUBS, 0, f_yin(16'h0020));
      add_vec(IR_SUBS, 0, f_op(16'h0020, A_SUB));
      add_vec(IR_SUBS, 0, f_wb(16'h0020));
      add_vec(IR_SUBS, 0, f_t0());
      add_vec(IR_ADD, 0, f_t1(1));
      add_vec(IR_ADD, 0, f_t2());
      add_vec(IR_ADD, 0, f_yin(16'h0004));
      add_vec(IR_ADD, 0, f_op(16'h0008, A_ADD));
      add_vec(IR_ADD, 0, f_wb(16'h0002));
      add_vec(IR_ADD, 1, f_idle(0, 0));
      add_vec(IR_ADD, 0, f_idle(0, 0));
      add_vec(IR_ADD, 0, f_idle(0, 0));

      repeat (2) @(negedge Clock);
      check_outs("reset_dut1", act1, '0);
      check_outs("reset_dut3", act3, '0);

      Clear = 1'b0;
      foreach (tbl[i]) begin
         IR1   = tbl[i].ir;
         Stop1 = tbl[i].stop;
         step();
         check_outs($sformatf("tbl[%0d]", i), act1, tbl[i].exp);
      end

      // halt opcode on dut1 alongside a MEM_LAT=3 nop on dut3
      Stop1 = 1'b0;
      Clear = 1'b1;
      IR1   = IR_HALT;
      @(negedge Clock);
      check_outs("clear_dut1", act1, '0);
      check_outs("clear_dut3", act3, '0);
      e1[0] = f_t0();       e3[0] = f_t0();
      e1[1] = f_t1(1);      e3[1] = f_t1(1);
      e1[2] = f_t2();       e3[2] = f_t1(0);
      e1[3] = f_idle(1, 0); e3[3] = f_t1(0);
      e1[4] = f_idle(0, 0); e3[4] = f_t2();
      e1[5] = f_idle(0, 0); e3[5] = f_idle(1, 0);
      e1[6] = f_idle(0, 0); e3[6] = f_t0();
      Clear = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         check_outs($sformatf("halt_op[%0d]", k), act1, e1[k]);
         check_outs($sformatf("lat3_nop[%0d]", k), act3, e3[k]);
      end

      // undefined opcode: sticky Illegal, HALT held, async Clear clears it
      Clear = 1'b1;
      IR1   = IR_UNDEF;
      @(negedge Clock);
      Clear = 1'b0;
      step(); check_outs("undef_t0", act1, f_t0());
      step(); check_outs("undef_t1", act1, f_t1(1));
      step(); check_outs("undef_t2", act1, f_t2());
      step(); check_outs("undef_t3", act1, f_idle(1, 0));
      eh = f_idle(0, 1);
      for (int k = 0; k < 20; k++) begin
         step();
         check_outs($sformatf("undef_halt[%0d]", k), act1, eh);
      end
      @(posedge Clock);
      #2 Clear = 1'b1;
      #1 check_outs("undef_clear_async", act1, '0);

      // Clear mid-T4 of a sub aborts with no writeback
      IR1 = IR_SUB;
      @(negedge Clock);
      Clear = 1'b0;
      step(); check_outs("sub_t0", act1, f_t0());
      step(); check_outs("sub_t1", act1, f_t1(1));
      step(); check_outs("sub_t2", act1, f_t2());
      step(); check_outs("sub_t3", act1, f_yin(16'h0004));
      step(); check_outs("sub_t4", act1, f_op(16'h0008, A_SUB));
      #2 Clear = 1'b1;
      #1 check_outs("abort_async", act1, '0);
      @(negedge Clock);
      check_outs("abort_hold", act1, '0);
      Clear = 1'b0;
      step(); check_outs("restart_t0", act1, f_t0());
      step(); check_outs("restart_t1", act1, f_t1(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
